inst_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer in front of the single-cycle core's combinational instruction ROM.
- Owns the PC register and drives the ROM byte address.
- Captures the returned {pc, instr} pairs into a small flushable queue and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and reloading the PC.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/inst_fetch_ctrl.sv | 97 +++++++++
 tb/tb_inst_fetch_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   FETCH_AW / FETCH_DW : address / instruction widths of a queued fetch entry
//   INSTR_BYTES         : byte stride between consecutive instructions
//   PC_ALIGN_BITS       : low PC bits forced to zero (word alignment)
//   fetch_entry_t       : {pc, instr} pair held in the fetch queue
package fetch_pkg;

  localparam int unsigned FETCH_AW      = 32;
  localparam int unsigned FETCH_DW      = 32;
  localparam int unsigned INSTR_BYTES   = 4;
  localparam int unsigned PC_ALIGN_BITS = 2;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO of fetch entries.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write wdata_i (accepted when not full, or full with a pop)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : discard all entries; wins over push and pop
//   wdata_i    : entry to write
//   rdata_o    : head entry (read mux over the storage registers)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t        mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A full queue may still accept a write when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  // Pointer / occupancy next state; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, queues
// {pc, instr} pairs and hands them to decode over valid/ready; redirects
// flush the queue and reload the PC.
//   clk, rst        : clock, synchronous active-high reset
//   rom_addr        : byte address to the ROM (= pc_q)
//   rom_instr       : combinational ROM data for rom_addr
//   redirect_valid  : restart fetch at redirect_pc (priority over push/pop)
//   redirect_pc     : new fetch address, aligned down to a word
//   out_valid/ready : decode handshake
//   out_pc/instr    : head entry, driven to 0 while out_valid=0
//   misalign        : only with FETCH_MISALIGN_CHK_EN; one-cycle pulse after a
//                     redirect whose low address bits were non-zero
// AW/DW must match FETCH_AW/FETCH_DW in fetch_pkg.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned    AW       = FETCH_AW,
  parameter int unsigned    DW       = FETCH_DW,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int unsigned    DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_instr,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [DW-1:0] out_instr
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic          misalign
`endif
);

  logic [AW-1:0] pc_q, pc_d;
  logic          push_c, pop_c, full_c, empty_c;
  fetch_entry_t  wdata_c, head_c;

  assign rom_addr  = pc_q;
  assign out_valid = ~empty_c;
  assign pop_c     = out_valid & out_ready;
  assign push_c    = ~redirect_valid & (~full_c | pop_c);

  assign wdata_c.pc    = FETCH_AW'(pc_q);
  assign wdata_c.instr = FETCH_DW'(rom_instr);
  assign out_pc        = out_valid ? AW'(head_c.pc)    : '0;
  assign out_instr     = out_valid ? DW'(head_c.instr) : '0;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (redirect_valid),
    .wdata_i (wdata_c),
    .rdata_o (head_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  // PC next state: redirect target (word aligned) wins over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[AW-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
    end else if (push_c) begin
      pc_d = pc_q + AW'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign misalign   = misalign_q;
  assign misalign_d = redirect_valid & (|redirect_pc[PC_ALIGN_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  // Low redirect bits are intentionally dropped in this build.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[PC_ALIGN_BITS-1:0];
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: inputs change and outputs are sampled
// on the falling edge; the ROM is a small combinational model.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign       (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words 0..3 hold 0x11..0x44; elsewhere the word is its address xor a tag.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb rom_instr = rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, ins);
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", rom_addr, 32'h0);

    // Stream from reset with decode always ready.
    rst = 1'b0;
    tick();
    chk_out("s0", 32'h0, 32'h11);
    tick();
    chk_out("s1", 32'h4, 32'h22);
    tick();
    chk_out("s2", 32'h8, 32'h33);
    tick();
    chk_out("s3", 32'hC, 32'h44);

    // Stall five cycles: queue fills with 0xC, 0x10, then PC holds.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", out_pc, 32'hC);
      chk("stall_instr", out_instr, 32'h44);
      chk("stall_addr", rom_addr, 32'h14);
    end

    // Drain in order and keep streaming with no gap.
    out_ready = 1'b1;
    tick();
    chk_out("d0", 32'h10, 32'hC0DE_0010);
    tick();
    chk_out("d1", 32'h14, 32'hC0DE_0014);
    tick();
    chk_out("d2", 32'h18, 32'hC0DE_0018);

    // Redirect with a full queue and a simultaneous pop.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", rom_addr, 32'h40);
    tick();
    chk_out("rd0", 32'h40, 32'hC0DE_0040);
    tick();
    chk_out("rd1", 32'h44, 32'hC0DE_0044);

    // Redirect to the top word and wrap to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wr_valid", 32'(out_valid), 32'd0);
    tick();
    chk_out("wr0", 32'hFFFF_FFFC, 32'h3F21_FFFC);
    tick();
    chk_out("wr1", 32'h0, 32'h11);

    // Fill the queue, then reset mid-stream.
    out_ready = 1'b0;
    tick();
    chk("full_addr", rom_addr, 32'h8);
    rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_addr", rom_addr, 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_out("mr0", 32'h0, 32'h11);
    tick();
    chk_out("mr1", 32'h4, 32'h22);

    // Misaligned redirect target is aligned down.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("ma_valid", 32'(out_valid), 32'd0);
    chk("ma_addr", rom_addr, 32'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("ma_flag_hi", 32'(misalign), 32'd1);
`endif
    tick();
    chk_out("ma0", 32'h100, 32'hC0DE_0100);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("ma_flag_lo", 32'(misalign), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
